mul_arbiter: RTL

//  Shares one multi-cycle 32x32->64 signed MUL unit between two requesters (A, B).

---
 rtl/mul_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/mul_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mul_arbiter: shares one multi-cycle signed MUL unit between requesters A/B |
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
module mul_arbiter #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 127
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_a,
  input  logic [DATA_W-1:0]     a_multiplier,
  input  logic [DATA_W-1:0]     a_multiplicand,
  output logic                  ack_a,
  output logic                  done_a,
  input  logic                  req_b,
  input  logic [DATA_W-1:0]     b_multiplier,
  input  logic [DATA_W-1:0]     b_multiplicand,
  output logic                  ack_b,
  output logic                  done_b,
  output logic [2*DATA_W-1:0]   res_out,
  output logic                  err,
  output logic                  m_op_start,
  output logic                  m_op_clear,
  output logic [DATA_W-1:0]     m_multiplier,
  output logic [DATA_W-1:0]     m_multiplicand,
  input  logic                  m_op_done,
  input  logic [2*DATA_W-1:0]   m_result
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_clear = 2'd2;
  localparam logic [7:0] c_timeout  = 8'(TIMEOUT);

  logic [1:0] r_state;
  logic       r_owner_b;
  logic       r_last_b;
  logic [7:0] r_cnt;

  logic       w_req_any;
  logic       w_grant_b;

  // On a tie the requester that was not served last wins.
  assign w_req_any = req_a | req_b;
  assign w_grant_b = req_b & (~req_a | ~r_last_b);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= c_st_idle;
      r_owner_b      <= 1'b0;
      r_last_b       <= 1'b1;
      r_cnt          <= 8'd0;
      ack_a          <= 1'b0;
      ack_b          <= 1'b0;
      done_a         <= 1'b0;
      done_b         <= 1'b0;
      res_out        <= '0;
      err            <= 1'b0;
      m_op_start     <= 1'b0;
      m_op_clear     <= 1'b0;
      m_multiplier   <= '0;
      m_multiplicand <= '0;
    end else begin
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      done_a     <= 1'b0;
      done_b     <= 1'b0;
      m_op_clear <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (w_req_any) begin
            ack_a          <= ~w_grant_b;
            ack_b          <= w_grant_b;
            m_multiplier   <= w_grant_b ? b_multiplier   : a_multiplier;
            m_multiplicand <= w_grant_b ? b_multiplicand : a_multiplicand;
            m_op_start     <= 1'b1;
            r_owner_b      <= w_grant_b;
            r_last_b       <= w_grant_b;
            r_cnt          <= 8'd0;
            r_state        <= c_st_run;
          end
        end
        c_st_run: begin
          // op_done takes priority over a coincident timeout.
          if (m_op_done) begin
            res_out    <= m_result;
            err        <= 1'b0;
            done_a     <= ~r_owner_b;
            done_b     <= r_owner_b;
            m_op_start <= 1'b0;
            m_op_clear <= 1'b1;
            r_state    <= c_st_clear;
          end else if (r_cnt == c_timeout) begin
            res_out    <= '0;
            err        <= 1'b1;
            done_a     <= ~r_owner_b;
            done_b     <= r_owner_b;
            m_op_start <= 1'b0;
            m_op_clear <= 1'b1;
            r_state    <= c_st_clear;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        c_st_clear: begin
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
